dcache_line_fill_ctrl: RTL

Miss/line-fill controller for the 4-way, 128-set, 64-byte-line data cache. It watches each access and the hit result, and picks a victim way on a miss. It then bursts the line in from the bus as four 128-bit beats and writes the data and tag arrays. It owns the per-way valid bit arrays that feed the data-cache hit logic, and handles line and global invalidates.

---
 rtl/dcache_line_fill_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/dcache_line_fill_ctrl.sv
// Miss/line-fill controller for a 4-way, 128-set, 64-byte-line data cache.
// Picks a victim, bursts four 128-bit beats, writes tag and owns the valid bits.
module dcache_line_fill_ctrl #(
    parameter int AWID  = 32,
    parameter int BEATS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [AWID-1:0]   adr,
    input  logic              hit,
    input  logic              inv_line,
    input  logic              inv_all,
    output logic              stall,
    output logic              bus_req,
    output logic [AWID-1:0]   bus_adr,
    input  logic              bus_ack,
    input  logic [127:0]      bus_dat,
    input  logic              bus_err,
    output logic              wr,
    output logic [1:0]        wr_way,
    output logic [6:0]        wr_ndx,
    output logic [1:0]        wr_beat,
    output logic [127:0]      wr_dat,
    output logic              tag_wr,
    output logic [AWID-7:0]   tag_out,
    output logic [3:0][127:0] valid,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_TAG   = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [3:0][127:0] valid_q, valid_d;
    logic [1:0]        rr_q, rr_d;
    logic [1:0]        beat_q, beat_d;
    logic [1:0]        way_q, way_d;
    logic [6:0]        ndx_q, ndx_d;
    logic [AWID-7:0]   tag_q, tag_d;
    logic [AWID-1:0]   bus_adr_q, bus_adr_d;
    logic              bus_req_q, bus_req_d;
    logic              wr_q, wr_d;
    logic [1:0]        wr_beat_q, wr_beat_d;
    logic [127:0]      wr_dat_q, wr_dat_d;
    logic              tag_wr_q, tag_wr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [6:0]        adr_ndx;
    logic [3:0]        set_valid;
    logic [2:0]        free_pick;

    // Returns {all_ways_valid, lowest invalid way}.
    function automatic logic [2:0] pick_free(input logic [3:0] v);
        logic [2:0] r;
        r = 3'b100;
        for (int w = 3; w >= 0; w--) begin
            if (!v[w]) begin
                r = {1'b0, 2'(w)};
            end
        end
        return r;
    endfunction

    assign adr_ndx   = adr[12:6];
    assign free_pick = pick_free(set_valid);
    assign stall     = (state_q != S_IDLE) || (req && !hit) || ((inv_line || inv_all) && req);

    assign bus_req = bus_req_q;
    assign bus_adr = bus_adr_q;
    assign wr      = wr_q;
    assign wr_way  = way_q;
    assign wr_ndx  = ndx_q;
    assign wr_beat = wr_beat_q;
    assign wr_dat  = wr_dat_q;
    assign tag_wr  = tag_wr_q;
    assign tag_out = tag_q;
    assign valid   = valid_q;
    assign done    = done_q;
    assign err     = err_q;

    // Valid bits of the addressed set across all ways, for victim selection.
    always_comb begin
        set_valid = 4'b0000;
        for (int w = 0; w < 4; w++) begin
            set_valid[w] = valid_q[w][adr_ndx];
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        rr_d      = rr_q;
        beat_d    = beat_q;
        way_d     = way_q;
        ndx_d     = ndx_q;
        tag_d     = tag_q;
        bus_adr_d = bus_adr_q;
        bus_req_d = bus_req_q;
        wr_d      = 1'b0;
        wr_beat_d = wr_beat_q;
        wr_dat_d  = wr_dat_q;
        tag_wr_d  = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Invalidates win; a same-cycle miss is retried while req is held.
                if (inv_all) begin
                    valid_d = '0;
                end else if (inv_line) begin
                    for (int w = 0; w < 4; w++) begin
                        valid_d[w][adr_ndx] = 1'b0;
                    end
                end else if (req && !hit) begin
                    if (free_pick[2]) begin
                        way_d = rr_q;
                        rr_d  = rr_q + 2'd1;
                        valid_d[rr_q][adr_ndx] = 1'b0;
                    end else begin
                        way_d = free_pick[1:0];
                        valid_d[free_pick[1:0]][adr_ndx] = 1'b0;
                    end
                    ndx_d     = adr_ndx;
                    tag_d     = adr[AWID-1:6];
                    bus_adr_d = adr & ~AWID'(6'h3f);
                    beat_d    = 2'd0;
                    bus_req_d = 1'b1;
                    state_d   = S_FILL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                if (bus_ack && bus_req_q) begin
                    wr_d      = 1'b1;
                    wr_beat_d = beat_q;
                    wr_dat_d  = bus_dat;
                    beat_d    = beat_q + 2'd1;
                end else begin
                    wr_d = 1'b0;
                end
                if (bus_err) begin
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_ABORT;
                end else if (bus_ack && beat_q == 2'(BEATS - 1)) begin
                    bus_req_d = 1'b0;
                    tag_wr_d  = 1'b1;
                    state_d   = S_TAG;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_TAG: begin
                valid_d[way_q][ndx_q] = 1'b1;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                bus_req_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            valid_q   <= '0;
            rr_q      <= 2'd0;
            beat_q    <= 2'd0;
            way_q     <= 2'd0;
            ndx_q     <= 7'd0;
            tag_q     <= '0;
            bus_adr_q <= '0;
            bus_req_q <= 1'b0;
            wr_q      <= 1'b0;
            wr_beat_q <= 2'd0;
            wr_dat_q  <= 128'd0;
            tag_wr_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            rr_q      <= rr_d;
            beat_q    <= beat_d;
            way_q     <= way_d;
            ndx_q     <= ndx_d;
            tag_q     <= tag_d;
            bus_adr_q <= bus_adr_d;
            bus_req_q <= bus_req_d;
            wr_q      <= wr_d;
            wr_beat_q <= wr_beat_d;
            wr_dat_q  <= wr_dat_d;
            tag_wr_q  <= tag_wr_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule
